// File: rtl/banked_data_mem.sv
`default_nettype none
// ============================================================================
//  Module      : banked_data_mem
//  Description : Multi-ported, word-interleaved banked data memory.
//                Per cycle each bank serves at most one access. Stores win
//                over loads at a bank (lowest store port first). Loads share
//                a bank round-robin. Load responses appear RD_LATENCY cycles
//                after acceptance, with byte/half extraction and sign or zero
//                extension. Misaligned requests complete without using a bank.
//  Ports       : clk, rst (async, active low), flush
//                ld_req_*  : valid/ready handshake plus addr, size, unsigned,
//                            tag, one set per load port
//                ld_resp_* : valid, err, data, tag, one set per load port
//                st_req_*  : valid/ready handshake plus addr, data, size,
//                            one set per store port
//                st_err    : one-cycle pulse after a misaligned store
//                conflict_cnt : saturating count of stalled-request cycles
//  Revision    : 1.0 - initial release
// ============================================================================
module banked_data_mem #(
    parameter int NUM_LD_PORTS = 2,
    parameter int NUM_ST_PORTS = 1,
    parameter int NUM_BANKS    = 4,
    parameter int BANK_DEPTH   = 256,
    parameter int RD_LATENCY   = 1,
    parameter int TAG_W        = 4
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   flush,
    input  logic [NUM_LD_PORTS-1:0]                ld_req_valid,
    output logic [NUM_LD_PORTS-1:0]                ld_req_ready,
    input  logic [NUM_LD_PORTS-1:0][31:0]          ld_req_addr,
    input  logic [NUM_LD_PORTS-1:0][1:0]           ld_req_size,
    input  logic [NUM_LD_PORTS-1:0]                ld_req_unsigned,
    input  logic [NUM_LD_PORTS-1:0][TAG_W-1:0]     ld_req_tag,
    output logic [NUM_LD_PORTS-1:0]                ld_resp_valid,
    output logic [NUM_LD_PORTS-1:0]                ld_resp_err,
    output logic [NUM_LD_PORTS-1:0][31:0]          ld_resp_data,
    output logic [NUM_LD_PORTS-1:0][TAG_W-1:0]     ld_resp_tag,
    input  logic [NUM_ST_PORTS-1:0]                st_req_valid,
    output logic [NUM_ST_PORTS-1:0]                st_req_ready,
    input  logic [NUM_ST_PORTS-1:0][31:0]          st_req_addr,
    input  logic [NUM_ST_PORTS-1:0][31:0]          st_req_data,
    input  logic [NUM_ST_PORTS-1:0][1:0]           st_req_size,
    output logic [NUM_ST_PORTS-1:0]                st_err,
    output logic [31:0]                            conflict_cnt
);

    localparam int c_BANK_BITS = $clog2(NUM_BANKS);
    localparam int c_ROW_BITS  = $clog2(BANK_DEPTH);
    localparam int c_BANK_W    = (c_BANK_BITS > 0) ? c_BANK_BITS : 1;
    localparam int c_ROW_W     = (c_ROW_BITS > 0) ? c_ROW_BITS : 1;
    localparam int c_PTR_W     = (NUM_LD_PORTS > 1) ? $clog2(NUM_LD_PORTS) : 1;

    // ------------------------------------------------------------------
    // Address / size helpers
    // ------------------------------------------------------------------
    function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] off);
        case (sz)
            2'b00:   is_misaligned = 1'b0;
            2'b01:   is_misaligned = off[0];
            2'b10:   is_misaligned = (off != 2'b00);
            default: is_misaligned = 1'b1;
        endcase
    endfunction

    function automatic logic [c_BANK_W-1:0] bank_of(input logic [31:0] a);
        if (c_BANK_BITS == 0) bank_of = '0;
        else                  bank_of = a[2 +: c_BANK_W];
    endfunction

    function automatic logic [c_ROW_W-1:0] row_of(input logic [31:0] a);
        row_of = a[2 + c_BANK_BITS +: c_ROW_W];
    endfunction

    function automatic logic [3:0] byte_en(input logic [1:0] sz, input logic [1:0] off);
        case (sz)
            2'b00:   byte_en = 4'b0001 << off;
            2'b01:   byte_en = 4'b0011 << off;
            default: byte_en = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] load_format(input logic [31:0] word, input logic [1:0] sz,
                                                input logic [1:0] off, input logic uns);
        logic [31:0] sh;
        sh = word >> {off, 3'b000};
        case (sz)
            2'b00:   load_format = uns ? {24'h0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
            2'b01:   load_format = uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: load_format = word;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic                                   w_en;
    logic [NUM_LD_PORTS-1:0][c_BANK_W-1:0]  w_ld_bank;
    logic [NUM_LD_PORTS-1:0][c_ROW_W-1:0]   w_ld_row;
    logic [NUM_LD_PORTS-1:0]                w_ld_mis;
    logic [NUM_ST_PORTS-1:0][c_BANK_W-1:0]  w_st_bank;
    logic [NUM_ST_PORTS-1:0][c_ROW_W-1:0]   w_st_row;
    logic [NUM_ST_PORTS-1:0]                w_st_mis;
    logic                                   w_unused_addr_bits;

    // No acceptance at all while in reset or during a flush cycle.
    assign w_en = rst & ~flush;

    always_comb begin
        w_ld_bank = '0;
        w_ld_row  = '0;
        w_ld_mis  = '0;
        w_st_bank = '0;
        w_st_row  = '0;
        w_st_mis  = '0;
        for (int p = 0; p < NUM_LD_PORTS; p++) begin
            w_ld_bank[p] = bank_of(ld_req_addr[p]);
            w_ld_row[p]  = row_of(ld_req_addr[p]);
            w_ld_mis[p]  = is_misaligned(ld_req_size[p], ld_req_addr[p][1:0]);
        end
        for (int s = 0; s < NUM_ST_PORTS; s++) begin
            w_st_bank[s] = bank_of(st_req_addr[s]);
            w_st_row[s]  = row_of(st_req_addr[s]);
            w_st_mis[s]  = is_misaligned(st_req_size[s], st_req_addr[s][1:0]);
        end
    end

    // Upper address bits alias by design.
    assign w_unused_addr_bits = ^{ld_req_addr, st_req_addr};

    // ------------------------------------------------------------------
    // Store arbitration: fixed priority, lowest port index first
    // ------------------------------------------------------------------
    logic [NUM_ST_PORTS-1:0]                w_st_grant;
    logic [NUM_BANKS-1:0]                   w_bank_st_busy;
    logic [NUM_BANKS-1:0][c_ROW_W-1:0]      w_bank_wr_row;
    logic [NUM_BANKS-1:0][31:0]             w_bank_wr_data;
    logic [NUM_BANKS-1:0][3:0]              w_bank_wr_be;

    always_comb begin
        w_st_grant     = '0;
        w_bank_st_busy = '0;
        w_bank_wr_row  = '0;
        w_bank_wr_data = '0;
        w_bank_wr_be   = '0;
        for (int s = 0; s < NUM_ST_PORTS; s++) begin
            if (w_en && st_req_valid[s] && !w_st_mis[s] && !w_bank_st_busy[w_st_bank[s]]) begin
                w_st_grant[s]                 = 1'b1;
                w_bank_st_busy[w_st_bank[s]]  = 1'b1;
                w_bank_wr_row[w_st_bank[s]]   = w_st_row[s];
                // Store data arrives LSB-aligned; move it onto its byte lanes.
                w_bank_wr_data[w_st_bank[s]]  = st_req_data[s] << {st_req_addr[s][1:0], 3'b000};
                w_bank_wr_be[w_st_bank[s]]    = byte_en(st_req_size[s], st_req_addr[s][1:0]);
            end
        end
    end

    // ------------------------------------------------------------------
    // Load arbitration: per-bank round-robin, only on banks no store owns
    // ------------------------------------------------------------------
    logic [NUM_BANKS-1:0][c_PTR_W-1:0]      r_rr;
    logic [NUM_LD_PORTS-1:0]                w_ld_grant;
    logic [NUM_BANKS-1:0]                   w_rr_upd;
    logic [NUM_BANKS-1:0][c_PTR_W-1:0]      w_rr_next;
    logic [NUM_BANKS-1:0][c_ROW_W-1:0]      w_bank_rd_row;

    always_comb begin
        logic found;
        int   idx;
        w_ld_grant    = '0;
        w_rr_upd      = '0;
        w_rr_next     = '0;
        w_bank_rd_row = '0;
        found         = 1'b0;
        idx           = 0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            found = 1'b0;
            for (int i = 0; i < NUM_LD_PORTS; i++) begin
                idx = (int'(r_rr[b]) + i) % NUM_LD_PORTS;
                if (w_en && !found && !w_bank_st_busy[b] && ld_req_valid[idx] &&
                    !w_ld_mis[idx] && (w_ld_bank[idx] == c_BANK_W'(b))) begin
                    found           = 1'b1;
                    w_ld_grant[idx] = 1'b1;
                    w_rr_upd[b]     = 1'b1;
                    w_rr_next[b]    = (idx + 1 == NUM_LD_PORTS) ? '0 : c_PTR_W'(idx + 1);
                    w_bank_rd_row[b] = w_ld_row[idx];
                end
            end
        end
    end

    // Misaligned requests never need a bank, so they only wait on flush/reset.
    assign ld_req_ready = w_ld_grant | ({NUM_LD_PORTS{w_en}} & ld_req_valid & w_ld_mis);
    assign st_req_ready = w_st_grant | ({NUM_ST_PORTS{w_en}} & st_req_valid & w_st_mis);

    // ------------------------------------------------------------------
    // Bank storage: byte-enabled write at the accepting edge, async read
    // of the row selected by this cycle's winning load.
    // ------------------------------------------------------------------
    logic [NUM_BANKS-1:0][31:0]             w_bank_rd;

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic [31:0] r_mem [BANK_DEPTH];

        always_ff @(posedge clk) begin
            if (w_bank_st_busy[b]) begin
                for (int k = 0; k < 4; k++) begin
                    if (w_bank_wr_be[b][k]) begin
                        r_mem[w_bank_wr_row[b]][8*k +: 8] <= w_bank_wr_data[b][8*k +: 8];
                    end
                end
            end
        end

        assign w_bank_rd[b] = r_mem[w_bank_rd_row[b]];
    end

    // ------------------------------------------------------------------
    // Load response pipeline
    // ------------------------------------------------------------------
    logic [NUM_LD_PORTS-1:0]                w_ld_fire;
    logic [NUM_LD_PORTS-1:0][31:0]          w_ld_fmt;

    assign w_ld_fire = ld_req_valid & ld_req_ready;

    always_comb begin
        w_ld_fmt = '0;
        for (int p = 0; p < NUM_LD_PORTS; p++) begin
            w_ld_fmt[p] = load_format(w_bank_rd[w_ld_bank[p]], ld_req_size[p],
                                      ld_req_addr[p][1:0], ld_req_unsigned[p]);
        end
    end

    logic [RD_LATENCY-1:0][NUM_LD_PORTS-1:0]             r_pv;
    logic [RD_LATENCY-1:0][NUM_LD_PORTS-1:0]             r_perr;
    logic [RD_LATENCY-1:0][NUM_LD_PORTS-1:0][31:0]       r_pdata;
    logic [RD_LATENCY-1:0][NUM_LD_PORTS-1:0][TAG_W-1:0]  r_ptag;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pv    <= '0;
            r_perr  <= '0;
            r_pdata <= '0;
            r_ptag  <= '0;
        end else if (flush) begin
            // Every stage is dropped, including the one about to be presented.
            r_pv    <= '0;
            r_perr  <= '0;
            r_pdata <= '0;
            r_ptag  <= '0;
        end else begin
            for (int p = 0; p < NUM_LD_PORTS; p++) begin
                r_pv[0][p]    <= w_ld_fire[p];
                r_perr[0][p]  <= w_ld_fire[p] & w_ld_mis[p];
                r_pdata[0][p] <= (w_ld_fire[p] && !w_ld_mis[p]) ? w_ld_fmt[p] : 32'h0;
                r_ptag[0][p]  <= w_ld_fire[p] ? ld_req_tag[p] : '0;
            end
            for (int k = 1; k < RD_LATENCY; k++) begin
                r_pv[k]    <= r_pv[k-1];
                r_perr[k]  <= r_perr[k-1];
                r_pdata[k] <= r_pdata[k-1];
                r_ptag[k]  <= r_ptag[k-1];
            end
        end
    end

    assign ld_resp_valid = r_pv[RD_LATENCY-1];
    assign ld_resp_err   = r_perr[RD_LATENCY-1];
    assign ld_resp_data  = r_pdata[RD_LATENCY-1];
    assign ld_resp_tag   = r_ptag[RD_LATENCY-1];

    // ------------------------------------------------------------------
    // Round-robin pointers, store error pulse, conflict counter
    // ------------------------------------------------------------------
    logic [NUM_ST_PORTS-1:0]                r_st_err;
    logic [31:0]                            r_conflict_cnt;
    logic                                   w_any_stall;

    assign w_any_stall = (|(ld_req_valid & ~ld_req_ready)) | (|(st_req_valid & ~st_req_ready));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rr           <= '0;
            r_st_err       <= '0;
            r_conflict_cnt <= '0;
        end else begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (w_rr_upd[b]) begin
                    r_rr[b] <= w_rr_next[b];
                end
            end
            r_st_err <= st_req_valid & st_req_ready & w_st_mis;
            if (w_any_stall && !flush && (r_conflict_cnt != 32'hFFFF_FFFF)) begin
                r_conflict_cnt <= r_conflict_cnt + 32'd1;
            end
        end
    end

    assign st_err       = r_st_err;
    assign conflict_cnt = r_conflict_cnt;

endmodule
`default_nettype wire

// File: tb/tb_banked_data_mem.sv
`default_nettype none
// ============================================================================
//  Module      : tb_banked_data_mem
//  Description : Self-checking bench for banked_data_mem (RD_LATENCY = 3).
//                Table of single-port store/load vectors followed by
//                hand-written multi-cycle sequences: store/load bank clash,
//                flush of in-flight loads, reset with loads in flight and
//                round-robin load arbitration with the conflict counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_banked_data_mem;

    localparam int c_LAT = 3;

    logic                  clk;
    logic                  rst;
    logic                  flush;
    logic [1:0]            ld_req_valid;
    logic [1:0]            ld_req_ready;
    logic [1:0][31:0]      ld_req_addr;
    logic [1:0][1:0]       ld_req_size;
    logic [1:0]            ld_req_unsigned;
    logic [1:0][3:0]       ld_req_tag;
    logic [1:0]            ld_resp_valid;
    logic [1:0]            ld_resp_err;
    logic [1:0][31:0]      ld_resp_data;
    logic [1:0][3:0]       ld_resp_tag;
    logic [0:0]            st_req_valid;
    logic [0:0]            st_req_ready;
    logic [0:0][31:0]      st_req_addr;
    logic [0:0][31:0]      st_req_data;
    logic [0:0][1:0]       st_req_size;
    logic [0:0]            st_err;
    logic [31:0]           conflict_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    banked_data_mem #(
        .NUM_LD_PORTS (2),
        .NUM_ST_PORTS (1),
        .NUM_BANKS    (4),
        .BANK_DEPTH   (256),
        .RD_LATENCY   (c_LAT),
        .TAG_W        (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .flush           (flush),
        .ld_req_valid    (ld_req_valid),
        .ld_req_ready    (ld_req_ready),
        .ld_req_addr     (ld_req_addr),
        .ld_req_size     (ld_req_size),
        .ld_req_unsigned (ld_req_unsigned),
        .ld_req_tag      (ld_req_tag),
        .ld_resp_valid   (ld_resp_valid),
        .ld_resp_err     (ld_resp_err),
        .ld_resp_data    (ld_resp_data),
        .ld_resp_tag     (ld_resp_tag),
        .st_req_valid    (st_req_valid),
        .st_req_ready    (st_req_ready),
        .st_req_addr     (st_req_addr),
        .st_req_data     (st_req_data),
        .st_req_size     (st_req_size),
        .st_err          (st_err),
        .conflict_cnt    (conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    // Wait (bounded) until the port shows ready at a falling edge.
    task automatic wait_ready(input bit is_st, input int p);
        int  n;
        bit  rdy;
        n = 0;
        @(negedge clk);
        rdy = is_st ? st_req_ready[p] : ld_req_ready[p];
        while (!rdy && n < 20) begin
            n++;
            @(negedge clk);
            rdy = is_st ? st_req_ready[p] : ld_req_ready[p];
        end
        if (!rdy) begin
            n_checks++;
            n_fail++;
            $display("FAIL ready_timeout (st=%0d port=%0d): ready 0, expected 1", is_st, p);
        end
    endtask

    // Tasks start and finish 1 time unit after a rising edge.
    task automatic st_op(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d,
                         input bit exp_err, input string nm);
        st_req_valid[0] = 1'b1;
        st_req_addr[0]  = a;
        st_req_size[0]  = sz;
        st_req_data[0]  = d;
        wait_ready(1'b1, 0);
        @(posedge clk); #1;
        st_req_valid[0] = 1'b0;
        chk({nm, "_st_err"}, 32'(st_err[0]), 32'(exp_err));
        @(posedge clk); #1;
        chk({nm, "_st_err_end"}, 32'(st_err[0]), 32'h0);
    endtask

    task automatic ld_op(input int p, input logic [31:0] a, input logic [1:0] sz, input bit u,
                         input logic [3:0] tg, input logic [31:0] exp_d, input bit exp_e,
                         input string nm);
        ld_req_valid[p]    = 1'b1;
        ld_req_addr[p]     = a;
        ld_req_size[p]     = sz;
        ld_req_unsigned[p] = u;
        ld_req_tag[p]      = tg;
        wait_ready(1'b0, p);
        @(posedge clk); #1;
        ld_req_valid[p] = 1'b0;
        for (int k = 1; k < c_LAT; k++) begin
            chk({nm, "_early"}, 32'(ld_resp_valid[p]), 32'h0);
            @(posedge clk); #1;
        end
        chk({nm, "_valid"}, 32'(ld_resp_valid[p]), 32'h1);
        chk({nm, "_data"},  ld_resp_data[p], exp_d);
        chk({nm, "_tag"},   32'(ld_resp_tag[p]), 32'(tg));
        chk({nm, "_err"},   32'(ld_resp_err[p]), 32'(exp_e));
        @(posedge clk); #1;
        chk({nm, "_once"},  32'(ld_resp_valid[p]), 32'h0);
    endtask

    typedef struct {
        bit          st;
        logic [31:0] addr;
        logic [1:0]  size;
        bit          uns;
        logic [31:0] data;
        logic [31:0] exp;
        bit          err;
    } vec_t;

    vec_t vecs[23];

    initial begin
        vecs[0]  = '{1'b1, 32'h0000_0040, 2'b10, 1'b0, 32'h8000_00FF, 32'h0,         1'b0};
        vecs[1]  = '{1'b0, 32'h0000_0040, 2'b00, 1'b0, 32'h0,         32'hFFFF_FFFF, 1'b0};
        vecs[2]  = '{1'b0, 32'h0000_0040, 2'b00, 1'b1, 32'h0,         32'h0000_00FF, 1'b0};
        vecs[3]  = '{1'b0, 32'h0000_0040, 2'b10, 1'b0, 32'h0,         32'h8000_00FF, 1'b0};
        vecs[4]  = '{1'b0, 32'h0000_0042, 2'b01, 1'b0, 32'h0,         32'hFFFF_8000, 1'b0};
        vecs[5]  = '{1'b0, 32'h0000_0042, 2'b01, 1'b1, 32'h0,         32'h0000_8000, 1'b0};
        vecs[6]  = '{1'b1, 32'h0000_0041, 2'b00, 1'b0, 32'h0000_005A, 32'h0,         1'b0};
        vecs[7]  = '{1'b0, 32'h0000_0040, 2'b10, 1'b0, 32'h0,         32'h8000_5AFF, 1'b0};
        vecs[8]  = '{1'b0, 32'h0000_0042, 2'b10, 1'b0, 32'h0,         32'h0,         1'b1};
        vecs[9]  = '{1'b1, 32'h0000_0043, 2'b01, 1'b0, 32'h0000_1234, 32'h0,         1'b1};
        vecs[10] = '{1'b0, 32'h0000_0040, 2'b10, 1'b0, 32'h0,         32'h8000_5AFF, 1'b0};
        vecs[11] = '{1'b1, 32'h0000_0042, 2'b01, 1'b0, 32'h0000_ABCD, 32'h0,         1'b0};
        vecs[12] = '{1'b0, 32'h0000_0043, 2'b00, 1'b1, 32'h0,         32'h0000_00AB, 1'b0};
        vecs[13] = '{1'b0, 32'h0000_0042, 2'b00, 1'b0, 32'h0,         32'hFFFF_FFCD, 1'b0};
        vecs[14] = '{1'b0, 32'h0000_0044, 2'b11, 1'b0, 32'h0,         32'h0,         1'b1};
        vecs[15] = '{1'b0, 32'h0000_1040, 2'b10, 1'b0, 32'h0,         32'hABCD_5AFF, 1'b0};
        vecs[16] = '{1'b1, 32'h0000_0044, 2'b10, 1'b0, 32'h1122_3344, 32'h0,         1'b0};
        vecs[17] = '{1'b0, 32'h0000_0044, 2'b01, 1'b0, 32'h0,         32'h0000_3344, 1'b0};
        vecs[18] = '{1'b0, 32'h0000_0047, 2'b00, 1'b0, 32'h0,         32'h0000_0011, 1'b0};
        vecs[19] = '{1'b1, 32'h0000_0000, 2'b10, 1'b0, 32'hA0A0_A0A0, 32'h0,         1'b0};
        vecs[20] = '{1'b1, 32'h0000_0010, 2'b10, 1'b0, 32'hB1B1_B1B1, 32'h0,         1'b0};
        vecs[21] = '{1'b1, 32'h0000_0004, 2'b10, 1'b0, 32'h4444_4444, 32'h0,         1'b0};
        vecs[22] = '{1'b0, 32'h0000_0012, 2'b01, 1'b0, 32'h0,         32'hFFFF_B1B1, 1'b0};

        rst             = 1'b0;
        flush           = 1'b0;
        ld_req_valid    = 2'b01;
        ld_req_addr     = '0;
        ld_req_size     = '0;
        ld_req_unsigned = '0;
        ld_req_tag      = '0;
        st_req_valid    = '0;
        st_req_addr     = '0;
        st_req_data     = '0;
        st_req_size     = '0;

        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ld_ready",   32'(ld_req_ready), 32'h0);
        chk("rst_resp_valid", 32'(ld_resp_valid), 32'h0);
        chk("rst_st_err",     32'(st_err), 32'h0);
        chk("rst_conflict",   conflict_cnt, 32'h0);
        ld_req_valid = 2'b00;
        #2 rst = 1'b1;
        @(posedge clk); #1;

        // ---------------- table vectors on port 0 ----------------
        for (int i = 0; i < 23; i++) begin
            if (vecs[i].st)
                st_op(vecs[i].addr, vecs[i].size, vecs[i].data, vecs[i].err, $sformatf("v%0d", i));
            else
                ld_op(0, vecs[i].addr, vecs[i].size, vecs[i].uns, 4'(i),
                      vecs[i].exp, vecs[i].err, $sformatf("v%0d", i));
        end

        // ---------------- store and load to the same bank ----------------
        st_req_valid[0] = 1'b1;
        st_req_addr[0]  = 32'h20;
        st_req_size[0]  = 2'b10;
        st_req_data[0]  = 32'hC3C3_C3C3;
        ld_req_valid[0] = 1'b1;
        ld_req_addr[0]  = 32'h20;
        ld_req_size[0]  = 2'b10;
        ld_req_unsigned[0] = 1'b0;
        ld_req_tag[0]   = 4'hC;
        @(negedge clk);
        chk("sl_st_ready", 32'(st_req_ready[0]), 32'h1);
        chk("sl_ld_ready", 32'(ld_req_ready[0]), 32'h0);
        @(posedge clk); #1;
        st_req_valid[0] = 1'b0;
        @(negedge clk);
        chk("sl_ld_ready2", 32'(ld_req_ready[0]), 32'h1);
        @(posedge clk); #1;
        ld_req_valid[0] = 1'b0;
        repeat (c_LAT - 1) @(posedge clk);
        #1;
        chk("sl_resp_valid", 32'(ld_resp_valid[0]), 32'h1);
        chk("sl_resp_data",  ld_resp_data[0], 32'hC3C3_C3C3);
        chk("sl_resp_tag",   32'(ld_resp_tag[0]), 32'hC);

        // ---------------- flush with loads in flight ----------------
        @(posedge clk); #1;
        ld_req_valid[0] = 1'b1;
        ld_req_addr[0]  = 32'h00;
        ld_req_tag[0]   = 4'h5;
        @(posedge clk); #1;                 // tag 5 accepted
        ld_req_addr[0]  = 32'h04;
        ld_req_tag[0]   = 4'h6;
        @(posedge clk); #1;                 // tag 6 accepted
        flush           = 1'b1;
        ld_req_addr[0]  = 32'h00;
        ld_req_tag[0]   = 4'h7;
        ld_req_valid[1] = 1'b1;             // misaligned: normally always ready
        ld_req_addr[1]  = 32'h41;
        ld_req_size[1]  = 2'b10;
        @(negedge clk);
        chk("fl_ld0_ready", 32'(ld_req_ready[0]), 32'h0);
        chk("fl_ld1_ready", 32'(ld_req_ready[1]), 32'h0);
        @(posedge clk); #1;                 // flush edge
        flush           = 1'b0;
        ld_req_valid[1] = 1'b0;
        chk("fl_resp_a", 32'(ld_resp_valid), 32'h0);
        @(posedge clk); #1;                 // tag 7 accepted
        ld_req_valid[0] = 1'b0;
        chk("fl_resp_b", 32'(ld_resp_valid), 32'h0);
        @(posedge clk); #1;
        chk("fl_resp_c", 32'(ld_resp_valid), 32'h0);
        @(posedge clk); #1;
        chk("fl_after_valid", 32'(ld_resp_valid[0]), 32'h1);
        chk("fl_after_tag",   32'(ld_resp_tag[0]), 32'h7);
        chk("fl_after_data",  ld_resp_data[0], 32'hA0A0_A0A0);
        @(posedge clk); #1;

        // ---------------- reset with loads in flight ----------------
        ld_req_valid[0] = 1'b1;
        ld_req_addr[0]  = 32'h00;
        ld_req_tag[0]   = 4'h8;
        @(posedge clk); #1;
        ld_req_addr[0]  = 32'h04;
        ld_req_tag[0]   = 4'h9;
        @(posedge clk); #1;
        ld_req_valid[0] = 1'b0;
        @(posedge clk); #1;
        chk("rs_pre_valid", 32'(ld_resp_valid[0]), 32'h1);
        chk("rs_pre_tag",   32'(ld_resp_tag[0]), 32'h8);
        chk("rs_pre_cnt",   conflict_cnt, 32'h1);
        #1 rst = 1'b0;
        ld_req_valid[0] = 1'b1;
        #1;
        chk("rs_valid", 32'(ld_resp_valid), 32'h0);
        chk("rs_data",  ld_resp_data[0], 32'h0);
        chk("rs_tag",   32'(ld_resp_tag[0]), 32'h0);
        chk("rs_cnt",   conflict_cnt, 32'h0);
        chk("rs_ready", 32'(ld_req_ready), 32'h0);
        @(posedge clk); @(posedge clk); #1;
        chk("rs_ready_hold", 32'(ld_req_ready), 32'h0);
        ld_req_valid[0] = 1'b0;
        #2 rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            chk($sformatf("rs_post_valid%0d", k), 32'(ld_resp_valid), 32'h0);
        end
        chk("rs_post_cnt", conflict_cnt, 32'h0);

        // ---------------- round-robin on one bank ----------------
        ld_req_valid    = 2'b11;
        ld_req_addr[0]  = 32'h00;
        ld_req_addr[1]  = 32'h10;
        ld_req_size     = {2'b10, 2'b10};
        ld_req_unsigned = 2'b00;
        ld_req_tag[0]   = 4'h1;
        ld_req_tag[1]   = 4'h2;
        @(negedge clk);
        chk("rr1_ready", 32'(ld_req_ready), 32'h1);
        @(posedge clk); #1;                 // E1: port0 tag1
        ld_req_tag[0] = 4'h3;
        @(negedge clk);
        chk("rr2_ready", 32'(ld_req_ready), 32'h2);
        @(posedge clk); #1;                 // E2: port1 tag2
        ld_req_tag[1] = 4'h4;
        @(negedge clk);
        chk("rr3_ready", 32'(ld_req_ready), 32'h1);
        @(posedge clk); #1;                 // E3: port0 tag3
        ld_req_valid[0] = 1'b0;
        chk("rr_resp0_valid", 32'(ld_resp_valid), 32'h1);
        chk("rr_resp0_tag",   32'(ld_resp_tag[0]), 32'h1);
        chk("rr_resp0_data",  ld_resp_data[0], 32'hA0A0_A0A0);
        @(negedge clk);
        chk("rr4_ready", 32'(ld_req_ready), 32'h2);
        @(posedge clk); #1;                 // E4: port1 tag4
        ld_req_valid[1] = 1'b0;
        chk("rr_resp1_valid", 32'(ld_resp_valid), 32'h2);
        chk("rr_resp1_tag",   32'(ld_resp_tag[1]), 32'h2);
        chk("rr_resp1_data",  ld_resp_data[1], 32'hB1B1_B1B1);
        chk("rr_conflict",    conflict_cnt, 32'h3);
        @(posedge clk); #1;
        chk("rr_resp2_valid", 32'(ld_resp_valid), 32'h1);
        chk("rr_resp2_tag",   32'(ld_resp_tag[0]), 32'h3);
        @(posedge clk); #1;
        chk("rr_resp3_valid", 32'(ld_resp_valid), 32'h2);
        chk("rr_resp3_tag",   32'(ld_resp_tag[1]), 32'h4);
        chk("rr_conflict_end", conflict_cnt, 32'h3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/banked_data_mem.md
BANKED_DATA_MEM -- requirements
Module: banked_data_mem

Interface
REQ-001 SHALL have parameter NUM_LD_PORTS, default 2, number of load ports.
REQ-002 SHALL have parameter NUM_ST_PORTS, default 1, number of store ports.
REQ-003 SHALL have parameter NUM_BANKS, default 4, power of two, word-interleaved banks.
REQ-004 SHALL have parameter BANK_DEPTH, default 256, 32-bit words per bank.
REQ-005 SHALL have parameter RD_LATENCY, default 1, range 1..3, load accept-to-response cycles.
REQ-006 SHALL have parameter TAG_W, default 4, load tag (ROB index) width.
REQ-007 SHALL have port clk, input, 1, sole clock; all state on rising edge.
REQ-008 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-009 SHALL have port flush, input, 1, kill in-flight loads, block acceptance this cycle.
REQ-010 SHALL have ports ld_req_valid / ld_req_ready, in / out, NUM_LD_PORTS, load handshake.
REQ-011 SHALL have ports ld_req_addr [32], ld_req_size [2], ld_req_unsigned [1], ld_req_tag [TAG_W], inputs, per load port.
REQ-012 SHALL have ports ld_resp_valid [1], ld_resp_err [1], ld_resp_data [32], ld_resp_tag [TAG_W], outputs, per load port.
REQ-013 SHALL have ports st_req_valid / st_req_ready, in / out, NUM_ST_PORTS, store handshake.
REQ-014 SHALL have ports st_req_addr [32], st_req_data [32], st_req_size [2], inputs, per store port.
REQ-015 SHALL have port st_err, output, NUM_ST_PORTS, one-cycle pulse for rejected (misaligned) store.
REQ-016 SHALL have port conflict_cnt, output, 32, saturating count of cycles with any valid-but-not-ready request.

Function
REQ-017 SHALL decode bank = addr[2+log2(NUM_BANKS)-1:2], row = next log2(BANK_DEPTH) bits; higher bits ignored (aliasing).
REQ-018 SHALL encode size 00 byte, 01 half, 10 word; 11 reserved, treated as misaligned.
REQ-019 SHALL flag misaligned: half with addr[0]=1, word with addr[1:0]!=0, or size 11.
REQ-020 SHALL transfer a request only when valid and ready are both high on a rising edge; requester holds fields stable until transfer.
REQ-021 SHALL compute ready combinationally from valids, addresses, flush; never from response state.
REQ-022 SHALL grant at most one access per bank per cycle; misaligned requests need no bank and are always ready (unless flush).
REQ-023 SHALL give stores priority over loads at a bank; among stores, lower port index wins.
REQ-024 SHALL arbitrate loads per bank round-robin: per-bank pointer advances to one past the granted load port after each load grant.
REQ-025 SHALL write stores at the accepting edge with byte enables from size and addr[1:0]; other bytes unchanged.
REQ-026 SHALL give a load accepted at edge N data reflecting all stores accepted at or before edge N-1.
REQ-027 SHALL present ld_resp_valid exactly RD_LATENCY cycles after acceptance, same port, with original tag; one response per port per cycle.
REQ-028 SHALL extract byte/half by addr[1:0], zero-extend if ld_req_unsigned else sign-extend; word passed through.
REQ-029 SHALL complete a misaligned load on the normal latency with ld_resp_err=1, ld_resp_data=0, no bank access.
REQ-030 SHALL not write on a misaligned store; st_err pulses the cycle after acceptance.
REQ-031 SHALL on flush high: deassert all ready; clear every in-flight load stage so no response from any load accepted before or at that edge appears.
REQ-032 SHALL increment conflict_cnt once per cycle where any valid request sees ready low and flush is low; hold at 0xFFFFFFFF.

Reset
REQ-033 SHALL on rst low asynchronously clear ld_resp_valid, ld_resp_err, ld_resp_data, ld_resp_tag, st_err, conflict_cnt, pipeline valids, all round-robin pointers to port 0.
REQ-034 SHALL hold ld_req_ready and st_req_ready low while rst is low; memory contents unaffected and undefined after power-up.
REQ-035 SHALL drop loads in flight when reset asserts mid-operation; no response after release.

Verification
REQ-036 SHALL cover: SW 0x8000_00FF @0x40, then LB/LBU @0x40 next cycle -> data 0xFFFFFFFF / 0x000000FF after RD_LATENCY, tags echoed.
REQ-037 SHALL cover: two loads same bank (0x00, 0x10, NUM_BANKS=4) 3 consecutive cycles -> grants alternate port0, port1, port0; conflict_cnt=3.
REQ-038 SHALL cover: store and load same bank same cycle -> store accepted, load ready=0, load accepted next cycle and returns new data.
REQ-039 SHALL cover: LW @0x42 -> ld_resp_err=1, data 0; SH @0x43 -> st_err pulse, memory at 0x40 unchanged.
REQ-040 SHALL cover: RD_LATENCY=3, loads accepted 2 cycles, flush next cycle -> zero ld_resp_valid; load after flush returns normally.
REQ-041 SHALL cover: rst low with loads in flight -> outputs zero immediately; no response after release; conflict_cnt=0.
